// File: rtl/game_flow_ctl_pkg.sv
// ---------------------------------------------------------------------------
// game_flow_ctl_pkg
// Shared definitions for the Death Race game sequencer: the screen state
// codes (one-hot, so each screen select is a bare state-register bit), the
// default timing parameters and the end-of-round "best score" helper.
// ---------------------------------------------------------------------------
package game_flow_ctl_pkg;

    // One-hot screen states; bit positions match the screen select outputs.
    typedef enum logic [4:0] {
        ST_TITLE     = 5'b00001,
        ST_WAIT      = 5'b00010,
        ST_GAME_ON   = 5'b00100,
        ST_TIME_OUT  = 5'b01000,
        ST_HIGHSCORE = 5'b10000
    } state_e;

    localparam int DEF_FPS           = 60;
    localparam int DEF_ROUND_SECONDS = 60;
    localparam int DEF_WAIT_FRAMES   = 180;
    localparam int DEF_SHOW_FRAMES   = 240;

    // Score that competes for the high-score slot at the end of a round.
    function automatic logic [7:0] best_score(input logic       dual,
                                              input logic [7:0] p1,
                                              input logic [7:0] p2);
        if (dual && (p2 > p1)) return p2;
        return p1;
    endfunction

endpackage

// File: rtl/game_flow_ctl_btn_frame_edge.sv
// ---------------------------------------------------------------------------
// btn_frame_edge
// Synchronizes a raw push button into the clk domain and samples it once per
// frame, which debounces at frame rate. A press is a 0->1 change between two
// consecutive frame samples and is reported as a one-clk pulse coincident
// with frame_tick.
//   clk, rst    : clock, asynchronous active-low reset
//   btn         : raw asynchronous button
//   frame_tick  : one-clk pulse per frame
//   press       : one-clk press pulse (only ever high together with frame_tick)
// ---------------------------------------------------------------------------
module btn_frame_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic frame_tick,
    output logic press
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic sample_q, sample_d;

    always_comb begin
        sync1_d  = btn;
        sync2_d  = sync1_q;
        sample_d = frame_tick ? sync2_q : sample_q;
    end

    // Current frame sample is the synchronized level; the stored one is the
    // previous frame's sample.
    assign press = frame_tick & sync2_q & ~sample_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sample_q <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            sample_q <= sample_d;
        end
    end

endmodule

// File: rtl/game_flow_ctl.sv
// ---------------------------------------------------------------------------
// game_flow_ctl
// Death Race game sequencer. Steps the display through the title, get-ready,
// game-on, time-out and high-score screens; owns the round timer, the
// single/dual player mode and the high-score register; gates the car sprites.
//   clk, rst          : pixel clock, asynchronous active-low reset
//   vsync             : VGA vsync, active-high (asynchronous to the logic)
//   btn_start/btn_mode: raw buttons
//   p1_score/p2_score : player scores, 8-bit binary
//   title_sel .. highscore : one-hot screen selects
//   dual/single       : player mode
//   car1_en/car2_en   : car sprite enables
//   time_left         : seconds remaining in the round
//   high_score        : best score since reset
//   new_record        : last round set a new high score
// ---------------------------------------------------------------------------
module game_flow_ctl
    import game_flow_ctl_pkg::*;
#(
    parameter int FPS           = DEF_FPS,
    parameter int ROUND_SECONDS = DEF_ROUND_SECONDS,
    parameter int WAIT_FRAMES   = DEF_WAIT_FRAMES,
    parameter int SHOW_FRAMES   = DEF_SHOW_FRAMES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       btn_start,
    input  logic       btn_mode,
    input  logic [7:0] p1_score,
    input  logic [7:0] p2_score,
    output logic       title_sel,
    output logic       wait_for_game,
    output logic       game_on,
    output logic       time_out,
    output logic       highscore,
    output logic       dual,
    output logic       single,
    output logic       car1_en,
    output logic       car2_en,
    output logic [6:0] time_left,
    output logic [7:0] high_score,
    output logic       new_record
);

    localparam logic [7:0] FPS_LAST   = 8'(FPS - 1);
    localparam logic [7:0] WAIT_LAST  = 8'(WAIT_FRAMES - 1);
    localparam logic [7:0] SHOW_LAST  = 8'(SHOW_FRAMES - 1);
    localparam logic [6:0] ROUND_LOAD = 7'(ROUND_SECONDS);

    // ---------------- vsync rising-edge detect -----------------------------
    // Two sync flops, an edge register, and a registered tick: the tick is
    // high in the third clk after vsync rises.
    logic vs_sync1_q, vs_sync2_q, vs_prev_q, frame_tick_q;
    logic frame_tick_d;

    always_comb frame_tick_d = vs_sync2_q & ~vs_prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_sync1_q   <= 1'b0;
            vs_sync2_q   <= 1'b0;
            vs_prev_q    <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            vs_sync1_q   <= vsync;
            vs_sync2_q   <= vs_sync1_q;
            vs_prev_q    <= vs_sync2_q;
            frame_tick_q <= frame_tick_d;
        end
    end

    // ---------------- buttons ----------------------------------------------
    logic start_press, mode_press;

    btn_frame_edge u_start (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn_start),
        .frame_tick (frame_tick_q),
        .press      (start_press)
    );

    btn_frame_edge u_mode (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn_mode),
        .frame_tick (frame_tick_q),
        .press      (mode_press)
    );

    // ---------------- sequencer --------------------------------------------
    state_e     state_q, state_d;
    logic       dual_q, dual_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [6:0] time_left_q, time_left_d;
    logic [7:0] high_score_q, high_score_d;
    logic       new_record_q, new_record_d;
    logic [7:0] best;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        dual_d       = dual_q;
        frame_cnt_d  = frame_cnt_q;
        time_left_d  = time_left_q;
        high_score_d = high_score_q;
        new_record_d = new_record_q;
        best         = best_score(dual_q, p1_score, p2_score);

        if (frame_tick_q) begin
            unique case (state_q)
                ST_TITLE: begin
                    // Mode toggle and start on the same frame both take effect.
                    if (mode_press) dual_d = ~dual_q;
                    if (start_press) begin
                        state_d      = ST_WAIT;
                        frame_cnt_d  = '0;
                        new_record_d = 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (frame_cnt_q == WAIT_LAST) begin
                        state_d     = ST_GAME_ON;
                        time_left_d = ROUND_LOAD;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
                ST_GAME_ON: begin
                    if (frame_cnt_q == FPS_LAST) begin
                        frame_cnt_d = '0;
                        time_left_d = time_left_q - 7'd1;
                        // Leave on the same clk the timer reaches zero.
                        if (time_left_q == 7'd1) state_d = ST_TIME_OUT;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
                ST_TIME_OUT: begin
                    if (frame_cnt_q == SHOW_LAST) begin
                        frame_cnt_d = '0;
                        if (best > high_score_q) begin
                            high_score_d = best;
                            new_record_d = 1'b1;
                            state_d      = ST_HIGHSCORE;
                        end else begin
                            state_d = ST_TITLE;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
                ST_HIGHSCORE: begin
                    if (start_press || (frame_cnt_q == SHOW_LAST)) begin
                        state_d     = ST_TITLE;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
                default: state_d = ST_TITLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_TITLE;
            dual_q       <= 1'b0;
            frame_cnt_q  <= '0;
            time_left_q  <= '0;
            high_score_q <= '0;
            new_record_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dual_q       <= dual_d;
            frame_cnt_q  <= frame_cnt_d;
            time_left_q  <= time_left_d;
            high_score_q <= high_score_d;
            new_record_q <= new_record_d;
        end
    end

    // ---------------- outputs ----------------------------------------------
    assign title_sel     = state_q[0];
    assign wait_for_game = state_q[1];
    assign game_on       = state_q[2];
    assign time_out      = state_q[3];
    assign highscore     = state_q[4];
    assign dual          = dual_q;
    assign single        = ~dual_q;
    assign car1_en       = state_q[2];
    assign car2_en       = state_q[2] & dual_q;
    assign time_left     = time_left_q;
    assign high_score    = high_score_q;
    assign new_record    = new_record_q;

endmodule

// File: tb/tb_game_flow_ctl.sv
// ---------------------------------------------------------------------------
// tb_game_flow_ctl
// Frame-level stimulus (buttons and scores change mid-frame, vsync every
// 100 clk). A reference model steps once per frame and pushes the expected
// output snapshot whenever it changes; a monitor pops and compares each time
// the DUT's outputs change.
// ---------------------------------------------------------------------------
module tb_game_flow_ctl;

    localparam int FPS   = 4;
    localparam int ROUND = 3;
    localparam int WAITF = 2;
    localparam int SHOW  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vsync = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_mode = 1'b0;
    logic [7:0] p1_score = '0;
    logic [7:0] p2_score = '0;
    logic       title_sel, wait_for_game, game_on, time_out, highscore;
    logic       dual, single, car1_en, car2_en, new_record;
    logic [6:0] time_left;
    logic [7:0] high_score;

    game_flow_ctl #(
        .FPS           (FPS),
        .ROUND_SECONDS (ROUND),
        .WAIT_FRAMES   (WAITF),
        .SHOW_FRAMES   (SHOW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .vsync         (vsync),
        .btn_start     (btn_start),
        .btn_mode      (btn_mode),
        .p1_score      (p1_score),
        .p2_score      (p2_score),
        .title_sel     (title_sel),
        .wait_for_game (wait_for_game),
        .game_on       (game_on),
        .time_out      (time_out),
        .highscore     (highscore),
        .dual          (dual),
        .single        (single),
        .car1_en       (car1_en),
        .car2_en       (car2_en),
        .time_left     (time_left),
        .high_score    (high_score),
        .new_record    (new_record)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model --------------------------------------
    localparam int M_TITLE = 0, M_WAIT = 1, M_GAME = 2, M_TOUT = 3, M_HS = 4;

    int         m_scr;
    bit         m_dual;
    int         m_elapsed;   // frames spent in the current screen
    int         m_tl;
    int         m_hs;
    bit         m_rec;
    bit         m_prev_start, m_prev_mode;
    logic [24:0] m_last;
    logic [24:0] sb[$];

    function automatic logic [24:0] model_snap();
        logic [4:0] oh;
        bit         g;
        oh = 5'b10000 >> m_scr;   // title is the MSB of the snapshot
        g  = (m_scr == M_GAME);
        return {oh, m_dual, ~m_dual, g, g & m_dual, 7'(m_tl), 8'(m_hs), m_rec};
    endfunction

    function automatic logic [24:0] dut_snap();
        return {title_sel, wait_for_game, game_on, time_out, highscore,
                dual, single, car1_en, car2_en, time_left, high_score, new_record};
    endfunction

    task automatic push_if_changed();
        logic [24:0] s;
        s = model_snap();
        if (s !== m_last) begin
            sb.push_back(s);
            m_last = s;
        end
    endtask

    task automatic model_reset();
        m_scr = M_TITLE; m_dual = 0; m_elapsed = 0; m_tl = 0; m_hs = 0; m_rec = 0;
        m_prev_start = 0; m_prev_mode = 0;
    endtask

    task automatic model_step(input bit st, input bit md);
        bit ps, pm;
        int best;
        ps = st && !m_prev_start;
        pm = md && !m_prev_mode;
        m_prev_start = st;
        m_prev_mode  = md;
        case (m_scr)
            M_TITLE: begin
                if (pm) m_dual = !m_dual;
                if (ps) begin m_scr = M_WAIT; m_elapsed = 0; m_rec = 0; end
            end
            M_WAIT: begin
                m_elapsed++;
                if (m_elapsed == WAITF) begin m_scr = M_GAME; m_elapsed = 0; m_tl = ROUND; end
            end
            M_GAME: begin
                m_elapsed++;
                m_tl = ROUND - m_elapsed / FPS;
                if (m_elapsed == ROUND * FPS) begin m_scr = M_TOUT; m_elapsed = 0; end
            end
            M_TOUT: begin
                m_elapsed++;
                if (m_elapsed == SHOW) begin
                    best = (m_dual && p2_score > p1_score) ? int'(p2_score) : int'(p1_score);
                    m_elapsed = 0;
                    if (best > m_hs) begin m_hs = best; m_rec = 1; m_scr = M_HS; end
                    else m_scr = M_TITLE;
                end
            end
            default: begin
                m_elapsed++;
                if (ps || m_elapsed == SHOW) begin m_scr = M_TITLE; m_elapsed = 0; end
            end
        endcase
        push_if_changed();
    endtask

    // ---------------- monitor ----------------------------------------------
    bit          mon_en = 0;
    logic [24:0] d_last;

    initial begin
        logic [24:0] cur;
        wait (mon_en);
        forever begin
            @(negedge clk);
            cur = dut_snap();
            if (cur !== d_last) begin
                if (sb.size() == 0) check("unexpected_change", 32'(cur), 32'(d_last));
                else check("snapshot", 32'(cur), 32'(sb.pop_front()));
                d_last = cur;
            end
        end
    end

    // ---------------- stimulus ---------------------------------------------
    // One 100-clk frame: buttons settle for 50 clk, then vsync pulses.
    task automatic frame(input bit st, input bit md);
        btn_start = st;
        btn_mode  = md;
        repeat (50) @(posedge clk);
        vsync = 1'b1;
        model_step(st, md);
        repeat (10) @(posedge clk);
        vsync = 1'b0;
        repeat (40) @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) frame(1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        btn_start = 1'b0;
        btn_mode  = 1'b0;
        model_reset();
        push_if_changed();
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check("async_reset", 32'(dut_snap()), 32'(model_snap()));
        check("async_reset_hs", 32'(high_score), 32'd0);
        repeat (5) @(posedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        m_last = model_snap();
        repeat (5) @(posedge clk);
        check("reset_state", 32'(dut_snap()), 32'(model_snap()));
        rst = 1'b1;
        d_last = dut_snap();
        mon_en = 1;

        // Idle title screen.
        idle(10);
        check("idle_title", 32'({title_sel, wait_for_game, game_on, time_out, highscore,
                                 dual, car1_en, time_left}), 32'({5'b10000, 1'b0, 1'b0, 7'd0}));

        // Dual round: mode then start; scores 0 so no record.
        frame(1'b0, 1'b1);
        check("dual_set", 32'(dual), 32'd1);
        frame(1'b1, 1'b0);
        idle(20);

        // Single round with p1=9, p2=50: record of 9.
        frame(1'b0, 1'b1);
        p1_score = 8'd9;
        p2_score = 8'd50;
        frame(1'b1, 1'b0);
        idle(20);
        check("record_hs", 32'(high_score), 32'd9);

        // Equal score is not a record.
        frame(1'b1, 1'b0);
        idle(20);
        check("equal_no_record", 32'({high_score, new_record}), 32'({8'd9, 1'b0}));

        // Start held across wait and round: one press only.
        p1_score = 8'd5;
        for (int i = 0; i < 24; i++) frame(1'b1, 1'b0);
        idle(2);

        // Reset in the middle of a round with two seconds left.
        frame(1'b1, 1'b0);
        idle(6);
        check("pre_reset_tl", 32'(time_left), 32'd2);
        pulse_reset();

        // Randomized frames.
        for (int i = 0; i < 160; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                p1_score = 8'($urandom_range(0, 255));
                p2_score = 8'($urandom_range(0, 255));
            end
            frame($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            if (i == 80) pulse_reset();
        end

        idle(2);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("final_state", 32'(dut_snap()), 32'(model_snap()));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
